// File: rtl/alu_op_scheduler_if.sv
// Requester/consumer bundle for alu_op_scheduler.
// res_zero/res_carry exist only when ALU_FLAGS_EN is defined.
interface alu_op_scheduler_if;
  localparam int unsigned DW  = 4;
  localparam int unsigned OPW = 2;

  logic           req0_valid;
  logic           req1_valid;
  logic [OPW-1:0] req0_op;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic           req0_ready;
  logic           req1_ready;
  logic           res_valid;
  logic [DW-1:0]  res_data;
  logic           res_id;
  logic           res_ready;
`ifdef ALU_FLAGS_EN
  logic           res_zero;
  logic           res_carry;
`endif

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
    output req0_a, req0_b, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id
`ifdef ALU_FLAGS_EN
    , input res_zero, res_carry
`endif
  );

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
    input  req0_a, req0_b, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id
`ifdef ALU_FLAGS_EN
    , output res_zero, res_carry
`endif
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin scheduler feeding a single 4-bit ALU with a held result register.
// Optional feature macro: ALU_FLAGS_EN (adds res_zero / res_carry).
module alu_op_scheduler #(
  parameter bit RR_INIT = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  alu_op_scheduler_if.slave  bus
);
  localparam int unsigned DW  = 4;
  localparam int unsigned OPW = 2;

  localparam logic [OPW-1:0] OP_AND = 2'b00;
  localparam logic [OPW-1:0] OP_OR  = 2'b01;
  localparam logic [OPW-1:0] OP_XOR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           id_q, id_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d;
  logic           res_valid_q, res_valid_d;
  logic           res_id_q, res_id_d;
  logic [DW-1:0]  res_data_q, res_data_d;
  logic [DW-1:0]  alu_c;
  logic           gnt0_c, gnt1_c;
`ifdef ALU_FLAGS_EN
  logic [DW:0]    sum_c;
  logic           carry_c;
  logic           res_zero_q, res_zero_d;
  logic           res_carry_q, res_carry_d;
`else
  logic [DW-1:0]  sum_c;
`endif

  // ALU on the latched operands
  always_comb begin
`ifdef ALU_FLAGS_EN
    sum_c   = {1'b0, a_q} + {1'b0, b_q};
    carry_c = (op_q == 2'b11) & sum_c[DW];
`else
    sum_c   = a_q + b_q;
`endif
    case (op_q)
      OP_AND:  alu_c = a_q & b_q;
      OP_OR:   alu_c = a_q | b_q;
      OP_XOR:  alu_c = a_q ^ b_q;
      default: alu_c = sum_c[DW-1:0];
    endcase
  end

  // Next-state, grant and datapath update
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;
`ifdef ALU_FLAGS_EN
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
`endif
    case (state_q)
      IDLE: begin
        // Ready is withheld while reset is asserted
        if (rst_n) begin
          gnt0_c = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
          gnt1_c = bus.req1_valid & (~bus.req0_valid |  ptr_q);
        end
        if (gnt0_c | gnt1_c) begin
          id_d    = gnt1_c;
          op_d    = gnt1_c ? bus.req1_op : bus.req0_op;
          a_d     = gnt1_c ? bus.req1_a  : bus.req0_a;
          b_d     = gnt1_c ? bus.req1_b  : bus.req0_b;
          ptr_d   = gnt0_c;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_c;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
        res_zero_d  = (alu_c == '0);
        res_carry_d = carry_c;
`endif
        state_d     = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= RR_INIT;
      id_q        <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
`ifdef ALU_FLAGS_EN
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
`ifdef ALU_FLAGS_EN
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
`endif
    end
  end

  assign bus.req0_ready = gnt0_c;
  assign bus.req1_ready = gnt1_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_id     = res_id_q;
`ifdef ALU_FLAGS_EN
  assign bus.res_zero   = res_zero_q;
  assign bus.res_carry  = res_carry_q;
`endif
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus random traffic checked every cycle
// against a transaction-level reference model.
module tb_alu_op_scheduler;
  localparam bit RR_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_on = 1'b0;

  alu_op_scheduler_if bus ();

  alu_op_scheduler #(.RR_INIT(RR_INIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: result of one operation as plain integer arithmetic
  typedef struct packed {
    logic [3:0] data;
    logic       id;
    logic       zero;
    logic       carry;
  } res_t;

  function automatic res_t alu_model(input logic [1:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic id);
    res_t r;
    int ai = int'(a);
    int bi = int'(b);
    int v;
    case (op)
      2'b00:   v = ai & bi;
      2'b01:   v = ai | bi;
      2'b10:   v = ai ^ bi;
      default: v = (ai + bi) % 16;
    endcase
    r.data  = 4'(v);
    r.id    = id;
    r.zero  = (v == 0);
    r.carry = (op == 2'b11) && (ai + bi > 15);
    return r;
  endfunction

  // phase 0: waiting for a request, 1: computing, 2: presenting result
  int   m_phase = 0;
  bit   m_ptr   = RR_INIT;
  bit   m_rv    = 1'b0;
  res_t m_pend  = '0;
  res_t m_out   = '0;

  function automatic logic [1:0] model_grant();
    if (!rst_n || m_phase != 0) return 2'b00;
    if (bus.req0_valid && bus.req1_valid) return m_ptr ? 2'b10 : 2'b01;
    if (bus.req0_valid) return 2'b01;
    if (bus.req1_valid) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] g;
    g = model_grant();
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = RR_INIT;
      m_rv    = 1'b0;
      m_out   = '0;
      m_pend  = '0;
    end else begin
      case (m_phase)
        0: if (g != 2'b00) begin
          m_pend  = g[1] ? alu_model(bus.req1_op, bus.req1_a, bus.req1_b, 1'b1)
                         : alu_model(bus.req0_op, bus.req0_a, bus.req0_b, 1'b0);
          m_ptr   = ~g[1];
          m_phase = 1;
        end
        1: begin
          m_out   = m_pend;
          m_rv    = 1'b1;
          m_phase = 2;
        end
        default: if (bus.res_ready) begin
          m_rv    = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  end

  // Every-cycle compare, sampled just after the falling edge
  always @(negedge clk) begin : compare
    logic [1:0] g;
    if (chk_on) begin
      #1;
      g = model_grant();
      check("req0_ready", 4'(bus.req0_ready), 4'(g[0]));
      check("req1_ready", 4'(bus.req1_ready), 4'(g[1]));
      check("res_valid",  4'(bus.res_valid),  4'(m_rv));
      check("res_data",   bus.res_data,       m_out.data);
      check("res_id",     4'(bus.res_id),     4'(m_out.id));
`ifdef ALU_FLAGS_EN
      check("res_zero",   4'(bus.res_zero),   4'(m_out.zero));
      check("res_carry",  4'(bus.res_carry),  4'(m_out.carry));
`endif
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_op = 2'b00;   bus.req1_op = 2'b00;
    bus.req0_a = 4'h0;     bus.req0_b = 4'h0;
    bus.req1_a = 4'h0;     bus.req1_b = 4'h0;
    bus.res_ready = 1'b0;
  endtask

  task automatic drive_req(input logic id, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic drain();
    int k = 0;
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #2;
    while (!bus.res_valid && k < 10) begin @(negedge clk); #2; k++; end
    check("drain_res_valid", 4'(bus.res_valid), 4'h1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  // One isolated operation: request until granted, then collect the result
  task automatic run_op(input logic id, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, output logic [3:0] d, output logic rid,
                        output logic z, output logic c, output int lat);
    int k = 0;
    @(negedge clk);
    drive_req(id, op, a, b);
    #2;
    while (!(id ? bus.req1_ready : bus.req0_ready) && k < 10) begin @(negedge clk); #2; k++; end
    check("op_granted", 4'(id ? bus.req1_ready : bus.req0_ready), 4'h1);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    lat = 1;
    #2;
    while (!bus.res_valid && lat < 10) begin @(negedge clk); #2; lat++; end
    d   = bus.res_data;
    rid = bus.res_id;
`ifdef ALU_FLAGS_EN
    z = bus.res_zero;
    c = bus.res_carry;
`else
    z = 1'b0;
    c = 1'b0;
`endif
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin : stim
    logic [3:0] d;
    logic       rid, z, c;
    int         lat;
    int         ngr, nres, guard;
    logic [3:0] gr_id [4];
    logic [3:0] rs_d  [4];
    logic [3:0] rs_id [4];

    idle_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    #2;
    check("rst_req0_ready", 4'(bus.req0_ready), 4'h0);
    check("rst_req1_ready", 4'(bus.req1_ready), 4'h0);
    check("rst_res_valid",  4'(bus.res_valid),  4'h0);
    check("rst_res_data",   bus.res_data,       4'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // AND 1100 & 1010 by req0
    run_op(1'b0, 2'b00, 4'hC, 4'hA, d, rid, z, c, lat);
    check("and_data", d, 4'h8);
    check("and_id", 4'(rid), 4'h0);
    check("and_latency", 4'(lat), 4'h2);

    // OR 0001 | 0110 by req1
    run_op(1'b1, 2'b01, 4'h1, 4'h6, d, rid, z, c, lat);
    check("or_data", d, 4'h7);
    check("or_id", 4'(rid), 4'h1);

    // Both held valid: grants alternate starting from req0
    ngr = 0; nres = 0; guard = 0;
    @(negedge clk);
    drive_req(1'b0, 2'b11, 4'h7, 4'h3);
    drive_req(1'b1, 2'b10, 4'hF, 4'h5);
    bus.res_ready = 1'b1;
    while (nres < 4 && guard < 40) begin
      #2;
      if (ngr < 4 && bus.req0_ready) begin gr_id[ngr] = 4'h0; ngr++; end
      else if (ngr < 4 && bus.req1_ready) begin gr_id[ngr] = 4'h1; ngr++; end
      if (bus.res_valid && bus.res_ready) begin
        rs_d[nres] = bus.res_data; rs_id[nres] = 4'(bus.res_id); nres++;
      end
      @(negedge clk);
      if (ngr == 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
      guard++;
    end
    bus.res_ready = 1'b0;
    check("rr_result_count", 4'(nres), 4'h4);
    for (int i = 0; i < 4; i++) begin
      if (i < nres) begin
        check("rr_grant", gr_id[i], 4'(i % 2));
        check("rr_data",  rs_d[i],  4'hA);
        check("rr_id",    rs_id[i], 4'(i % 2));
      end
    end

    // Flag cases; data checked in every build
    run_op(1'b0, 2'b11, 4'h9, 4'h8, d, rid, z, c, lat);
    check("add_wrap_data", d, 4'h1);
`ifdef ALU_FLAGS_EN
    check("add_wrap_carry", 4'(c), 4'h1);
    check("add_wrap_zero",  4'(z), 4'h0);
`endif
    run_op(1'b0, 2'b00, 4'h5, 4'hA, d, rid, z, c, lat);
    check("and_zero_data", d, 4'h0);
`ifdef ALU_FLAGS_EN
    check("and_zero_zero",  4'(z), 4'h1);
    check("and_zero_carry", 4'(c), 4'h0);
`endif

    // Result held while consumer stalls; req1 keeps toggling operands
    @(negedge clk);
    drive_req(1'b1, 2'b11, 4'h3, 4'h4);
    #2;
    check("hold_grant", 4'(bus.req1_ready), 4'h1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("hold_valid", 4'(bus.res_valid), 4'h1);
      check("hold_data",  bus.res_data,      4'h7);
      check("hold_id",    4'(bus.res_id),    4'h1);
      check("hold_req1_ready", 4'(bus.req1_ready), 4'h0);
      @(negedge clk);
      bus.req1_a = 4'($urandom);
      bus.req1_b = 4'($urandom);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #2;
    check("release_valid", 4'(bus.res_valid), 4'h0);
    check("release_regrant", 4'(bus.req1_ready), 4'h1);
    drain();

    // Reset while computing discards the operation
    @(negedge clk);
    drive_req(1'b0, 2'b01, 4'h2, 4'h4);
    #2;
    check("abort_grant", 4'(bus.req0_ready), 4'h1);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("abort_no_result", 4'(bus.res_valid), 4'h0);
      @(negedge clk);
    end
    drive_req(1'b0, 2'b00, 4'h1, 4'h1);
    drive_req(1'b1, 2'b00, 4'h1, 4'h1);
    #2;
    check("abort_ptr_init", 4'(bus.req0_ready), 4'(!RR_INIT));
    drain();

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n          = ($urandom_range(0, 149) != 0);
      bus.req0_valid = ($urandom_range(0, 9) < 6);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      bus.req0_op    = 2'($urandom);
      bus.req1_op    = 2'($urandom);
      bus.req0_a     = 4'($urandom);
      bus.req0_b     = 4'($urandom);
      bus.req1_a     = 4'($urandom);
      bus.req1_b     = 4'($urandom);
      bus.res_ready  = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 Parameter: RR_INIT, default 0, requester favoured by the round-robin pointer after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 req0_valid, req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_op, req1_op  input  2 each  opcode: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  4 each  operands.
REQ-007 req0_ready, req1_ready  output  1 each  scheduler accepts the requester's operation this cycle.
REQ-008 res_valid  output  1  result register holds a valid result.
REQ-009 res_data  output  4  operation result.
REQ-010 res_id  output  1  requester that issued the result.
REQ-011 res_ready  input  1  consumer accepts the result this cycle.

Function
REQ-012 The FSM shall have states IDLE, EXEC and DONE; any unreachable encoding shall return to IDLE on the next edge.
REQ-013 In IDLE, the block shall assert at most one reqN_ready (combinational from the valids and the pointer); both ready outputs shall be 0 in EXEC and DONE.
REQ-014 Grant: only one valid -> grant that requester; both valid -> grant the pointer's requester; none valid -> no grant, stay in IDLE.
REQ-015 A transfer (valid & ready) shall latch op, a, b and id, move to EXEC, and set the pointer to the other requester.
REQ-016 The pointer shall change only on a transfer.
REQ-017 EXEC shall compute the latched operation into res_data in exactly one cycle and move to DONE, with res_valid=1 from the DONE cycle onward.
REQ-018 Latency: result visible on the second rising edge after the transfer edge; minimum spacing between transfers is 3 cycles.
REQ-019 AND/OR/XOR shall be bitwise on 4 bits; ADD shall return a + b mod 16.
REQ-020 In DONE, res_valid, res_data and res_id shall hold stable until res_ready=1; on that edge the FSM shall move to IDLE and clear res_valid.
REQ-021 res_ready while res_valid=0 shall be ignored.
REQ-022 Requester inputs that change while not granted shall have no effect; a valid request shall wait indefinitely with no timeout.
REQ-023 Fairness: with both requesters continuously valid, grants shall strictly alternate.

Reset
REQ-024 With rst_n=0 at a rising edge: state=IDLE, res_valid=0, res_data=0000, res_id=0, latched operands and op=0, pointer=RR_INIT.
REQ-025 During reset cycles, both reqN_ready outputs shall be 0.
REQ-026 Reset during EXEC or DONE shall discard the in-flight operation with no result delivered.

Configuration
REQ-027 Macro ALU_FLAGS_EN defined: add outputs res_zero (1 when res_data==0) and res_carry (carry-out of ADD, 0 for other ops). Both are registered with res_data, held stable in DONE, and reset to 0.
REQ-028 Macro ALU_FLAGS_EN undefined: res_zero and res_carry ports are absent and the ADD carry is discarded; all other behaviour is identical.

Verification
REQ-029 Reset then req0 only: op=00, a=1100, b=1010 -> req0_ready=1 in the same cycle; two edges later res_data=1000, res_id=0.
REQ-030 Both valid, RR_INIT=0, req0 ADD 0111+0011 and req1 XOR 1111^0101 held valid -> results 1010 (id 0) then 1010 (id 1); grants alternate 0,1,0,1.
REQ-031 ADD 1001+1000 with ALU_FLAGS_EN -> res_data=0001, res_carry=1, res_zero=0; AND 0101&1010 -> res_data=0000, res_zero=1, res_carry=0.
REQ-032 res_ready held 0 for 5 cycles in DONE, with req1 toggling its operands -> res_* stable, req1_ready=0; res_ready=1 -> IDLE next cycle, then req1 granted.
REQ-033 rst_n=0 for one cycle during EXEC -> res_valid stays 0, no result emitted, pointer=RR_INIT, IDLE next cycle.
REQ-034 OR 0001|0110 by req1 while req0 idle -> res_data=0111, res_id=1, pointer moves to 0.
